// File: rtl/fp32_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with a start/done handshake.
// Denormals are flushed to zero and alignment truncates, so there is no rounding step.
module fp32_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_PACK  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d, sub_q, sub_d, sp_q, sp_d, done_q, done_d;
  logic [9:0]  exp_q, exp_d;
  logic [24:0] mx_q, mx_d, my_q, my_d;
  logic [31:0] spv_q, spv_d, result_q, result_d;

  logic [7:0]  ea, eb, ex, ey, ediff;
  logic [23:0] ma, mb, mx, my, my_sh;
  logic        sa, sb, sx, a_nan, b_nan, a_inf, b_inf, a_big;

  // Operand unpacking is pure wiring off the captured registers.
  always_comb begin
    sa    = a_q[31];
    sb    = b_q[31];
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    a_nan = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_big = {ea, ma} >= {eb, mb};
    sx    = a_big ? sa : sb;
    ex    = a_big ? ea : eb;
    ey    = a_big ? eb : ea;
    mx    = a_big ? ma : mb;
    my    = a_big ? mb : ma;
    ediff = ex - ey;
    my_sh = (ediff >= 8'd25) ? 24'd0 : (my >> ediff);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    sub_d    = sub_q;
    sp_d     = sp_q;
    spv_d    = spv_q;
    exp_d    = exp_q;
    mx_d     = mx_q;
    my_d     = my_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {op, 31'd0};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sp_d = 1'b1;
        state_d = S_PACK;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
          spv_d = 32'h7FC0_0000;
        else if (a_inf)
          spv_d = {sa, 8'hFF, 23'd0};
        else if (b_inf)
          spv_d = {sb, 8'hFF, 23'd0};
        else begin
          sp_d    = 1'b0;
          sgn_d   = sx;
          sub_d   = sa ^ sb;
          exp_d   = {2'b00, ex};
          mx_d    = {1'b0, mx};
          my_d    = {1'b0, my_sh};
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mx_d    = sub_q ? (mx_q - my_q) : (mx_q + my_q);
        state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_PACK;
        if (mx_q == 25'd0) begin
          sgn_d = 1'b0;
          exp_d = 10'd0;
        end else if (mx_q[24]) begin
          mx_d  = mx_q >> 1;
          exp_d = exp_q + 10'd1;
        end else if (mx_q[23]) begin
          state_d = S_PACK;
        end else if (exp_q == 10'd1) begin
          // Underflow past the smallest normal flushes to +0.
          sgn_d = 1'b0;
          exp_d = 10'd0;
          mx_d  = 25'd0;
        end else begin
          mx_d    = mx_q << 1;
          exp_d   = exp_q - 10'd1;
          state_d = S_NORM;
        end
      end
      S_PACK: begin
        if (sp_q)
          result_d = spv_q;
        else if (exp_q >= 10'd255)
          result_d = {sgn_q, 8'hFF, 23'd0};
        else
          result_d = {sgn_q, exp_q[7:0], mx_q[22:0]};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sgn_q    <= 1'b0;
      sub_q    <= 1'b0;
      sp_q     <= 1'b0;
      spv_q    <= 32'd0;
      exp_q    <= 10'd0;
      mx_q     <= 25'd0;
      my_q     <= 25'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      sub_q    <= sub_d;
      sp_q     <= sp_d;
      spv_q    <= spv_d;
      exp_q    <= exp_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Directed scoreboard bench for fp32_addsub_seq: results and latencies are queued at issue.
module tb_fp32_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  fp32_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic collect(input string tag, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // Drives start from the current point in time; accepted at the next rising edge.
  task automatic go(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                    input logic opi, input logic [31:0] expv, input int lat);
    exp_t e;
    e.res = expv;
    e.lat = lat;
    sb.push_back(e);
    a = ai; b = bi; op = opi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    collect(tag, 0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); go("neg_double",  32'hC0933333, 32'hC0933333, 1'b0, 32'hC1133333, 4);
    @(negedge clk); go("mixed_sign",  32'hC0933333, 32'h3F199999, 1'b0, 32'hC0800000, 4);
    @(negedge clk); go("sub_3p2",     32'h404CCCCC, 32'h3F199999, 1'b1, 32'h40266666, 4);
    @(negedge clk); go("carry_trunc", 32'h450A70CC, 32'h4509D199, 1'b0, 32'h458A2132, 4);
    @(negedge clk); go("one_m_one",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4);
    @(negedge clk); go("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2);
    @(negedge clk); go("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
    @(negedge clk); go("lshift2",     32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 6);
    @(negedge clk); go("lshift23",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 27);
    @(negedge clk); go("uflow_flush", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4);
    @(negedge clk); go("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2);
    @(negedge clk); go("fin_m_inf",   32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2);
    @(negedge clk); go("denorm",      32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4);
    @(negedge clk); go("far_shift",   32'h4C000000, 32'h3F800000, 1'b0, 32'h4C000000, 4);
    // New start issued in the done cycle must be accepted.
    go("b2b_again", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);

    // Start while busy is ignored; the in-flight result survives.
    @(negedge clk);
    begin
      exp_t e;
      e.res = 32'h40000000; e.lat = 4;
      sb.push_back(e);
    end
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    a = 32'h40400000; b = 32'h40400000; op = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    collect("busy_start", 2);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("no_queued_op", seen, 0);

    // Reset while in NORM (two left shifts pending).
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F400000; op = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);

    @(negedge clk); go("post_rst", 32'hC0933333, 32'hC0933333, 1'b0, 32'hC1133333, 4);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
